// File: rtl/hv_pkg.sv
// Shared hypervector definitions: rotate direction, default width and a reference rotate
// function for models and assertions.
package hv_pkg;

  localparam int unsigned HV_DIM_DEFAULT = 1024;

  typedef enum logic {
    PERM_RIGHT = 1'b0,  // bit i -> i-amt
    PERM_LEFT  = 1'b1   // bit i -> i+amt
  } perm_dir_e;

  // Rotate right by amt within the low dim bits of vec; bits at and above dim read as zero.
  function automatic logic [HV_DIM_DEFAULT-1:0] hv_rotr(
    input logic [HV_DIM_DEFAULT-1:0] vec,
    input int unsigned               amt,
    input int unsigned               dim = HV_DIM_DEFAULT
  );
    logic [HV_DIM_DEFAULT-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < dim; i++) begin
      res[i] = vec[(i + amt) % dim];
    end
    return res;
  endfunction

endpackage

// File: rtl/hv_rot_stage.sv
// Single combinational barrel-rotator stage: rotates right by SHIFT when en_i is set,
// otherwise passes data through.
//   en_i   : apply this stage's rotation
//   data_i : incoming vector
//   data_o : rotated or passed vector
module hv_rot_stage #(
  parameter int unsigned DIM   = 1024,
  parameter int unsigned SHIFT = 1
) (
  input  logic           en_i,
  input  logic [DIM-1:0] data_i,
  output logic [DIM-1:0] data_o
);

  assign data_o = en_i ? {data_i[SHIFT-1:0], data_i[DIM-1:SHIFT]} : data_i;

endmodule

// File: rtl/permute_pipe.sv
// Pipelined barrel rotator for DIM-bit hypervectors with valid/ready flow control.
// SHW = log2(DIM) conditional rotate stages; a register follows every SPR stages and the last.
//   clk, rst_n              : clock, async active-low reset
//   in_valid_i / in_ready_o : input handshake
//   in_data_i, in_amt_i     : vector and rotate amount
//   in_dir_i                : perm_dir_e (0 right, 1 left)
//   in_tag_i / out_tag_o    : sideband carried unchanged with the vector
//   out_valid_o/out_ready_i : output handshake
//   out_data_o              : rotated vector
module permute_pipe
  import hv_pkg::*;
#(
  parameter  int unsigned DIM   = HV_DIM_DEFAULT,
  parameter  int unsigned SPR   = 1,
  parameter  int unsigned TAG_W = 8,
  localparam int unsigned SHW   = $clog2(DIM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DIM-1:0]   in_data_i,
  input  logic [SHW-1:0]   in_amt_i,
  input  logic             in_dir_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DIM-1:0]   out_data_o,
  output logic [TAG_W-1:0] out_tag_o
);

  localparam int unsigned NREG = (SHW + SPR - 1) / SPR;

  logic             adv;
  logic [SHW-1:0]   eff_amt;

  // Per-register-group sources (group 0 reads the input port, group g reads register g-1).
  logic [DIM-1:0]   grp_dat [NREG];
  logic [SHW-1:0]   grp_amt [NREG];
  logic [TAG_W-1:0] grp_tag [NREG];
  logic [NREG-1:0]  grp_vld;

  // Register contents, flattened for neighbouring groups and the output.
  logic [DIM-1:0]   dat_all [NREG];
  logic [SHW-1:0]   amt_all [NREG];
  logic [TAG_W-1:0] tag_all [NREG];
  logic [NREG-1:0]  vld_all;

  logic [DIM-1:0]   stg_out [SHW];

  // The whole pipe moves together; a stalled output freezes every stage, bubbles included.
  assign adv        = ~vld_all[NREG-1] | out_ready_i;
  assign in_ready_o = adv;

  // Left by k is right by DIM-k; two's-complement negate gives that modulo DIM.
  assign eff_amt = (in_dir_i == PERM_LEFT) ? (~in_amt_i) + SHW'(1) : in_amt_i;

  for (genvar g = 0; g < NREG; g++) begin : g_src
    if (g == 0) begin : g_in
      assign grp_dat[g] = in_data_i;
      assign grp_amt[g] = eff_amt;
      assign grp_tag[g] = in_tag_i;
      assign grp_vld[g] = in_valid_i;
    end else begin : g_prev
      assign grp_dat[g] = dat_all[g-1];
      assign grp_amt[g] = amt_all[g-1];
      assign grp_tag[g] = tag_all[g-1];
      assign grp_vld[g] = vld_all[g-1];
    end
  end

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int unsigned Grp = k / SPR;
    logic [DIM-1:0] stg_in;

    if (k % SPR == 0) begin : g_head
      assign stg_in = grp_dat[Grp];
    end else begin : g_link
      assign stg_in = stg_out[k-1];
    end

    // Each stage reads its own group's carried amount, so neighbouring vectors never mix.
    hv_rot_stage #(
      .DIM   (DIM),
      .SHIFT (2 ** k)
    ) u_stage (
      .en_i   (grp_amt[Grp][k]),
      .data_i (stg_in),
      .data_o (stg_out[k])
    );
  end

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    localparam int unsigned Last = ((g + 1) * SPR < SHW) ? (g + 1) * SPR - 1 : SHW - 1;

    logic             vld_q;
    logic [DIM-1:0]   dat_q;
    logic [SHW-1:0]   amt_q;
    logic [TAG_W-1:0] tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        dat_q <= '0;
        amt_q <= '0;
        tag_q <= '0;
      end else if (adv) begin
        vld_q <= grp_vld[g];
        dat_q <= stg_out[Last];
        amt_q <= grp_amt[g];
        tag_q <= grp_tag[g];
      end
    end

    assign vld_all[g] = vld_q;
    assign dat_all[g] = dat_q;
    assign amt_all[g] = amt_q;
    assign tag_all[g] = tag_q;
  end

  assign out_valid_o = vld_all[NREG-1];
  assign out_data_o  = dat_all[NREG-1];
  assign out_tag_o   = tag_all[NREG-1];

  // Vectors accepted minus vectors delivered; must always equal the occupied stages.
  int unsigned inflight_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_q + 32'(in_valid_i & adv) - 32'(out_valid_o & out_ready_i);
    end
  end

  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid_o && !out_ready_i |=> out_valid_o && $stable(out_data_o) && $stable(out_tag_o));

  a_no_loss: assert property (@(posedge clk) disable iff (!rst_n)
    inflight_q == 32'($countones(vld_all)));

endmodule
